// File: rtl/rda_fp_adder_pkg.sv
// Shared field widths, IEEE-754 single-precision constants and helpers
// for the two-stage floating-point adder.
package rda_fp_adder_pkg;

  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int SIG_W    = MAN_W + 1;
  localparam int ADD_W    = SIG_W + 1;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp_t;

  // Leading-zero count of a significand; returns SIG_W for an all-zero input.
  function automatic logic [4:0] lzc_sig(input logic [SIG_W-1:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = SIG_W - 1; i >= 0; i--) begin
      if (found) begin
        n = n;
      end else if (v[i]) begin
        found = 1'b1;
      end else begin
        n = n + 5'd1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/rda_fp_adder_if.sv
// Operand/result bundle of the floating-point adder; master drives operands,
// slave (the adder) returns the sum.
interface rda_fp_adder_if;

  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic [31:0] sum;

  modport master (output in_valid, a, b, input out_valid, sum);
  modport slave  (input in_valid, a, b, output out_valid, sum);

endinterface

// File: rtl/rda_fp_adder_rda.sv
// 25-bit ripple-carry adder with carry-in and carry-out used for the
// significand add/subtract.
module rda_fp_adder_rda
  import rda_fp_adder_pkg::*;
(
  input  logic [ADD_W-1:0] a,
  input  logic [ADD_W-1:0] b,
  input  logic             cin,
  output logic [ADD_W-1:0] s,
  output logic             cout
);

  logic [ADD_W:0] carry_s;

  assign carry_s[0] = cin;

  for (genvar i = 0; i < ADD_W; i++) begin : g_fa
    assign s[i]           = a[i] ^ b[i] ^ carry_s[i];
    assign carry_s[i + 1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
  end

  assign cout = carry_s[ADD_W];

endmodule

// File: rtl/rda_fp_adder.sv
// Two-stage IEEE-754 single-precision adder: swap/align/special detection,
// then add/normalize/pack. Denormals flush to zero; alignment truncates.
module rda_fp_adder
  import rda_fp_adder_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  rda_fp_adder_if.slave  bus
);

  fp_t              l_s, s_s;
  logic [SIG_W-1:0] sig_l_s, sig_s_s, align_s;
  logic [EXP_W-1:0] d_s;
  logic             nan_a_s, nan_b_s, inf_a_s, inf_b_s, special_s, neg_zero_s;
  logic [31:0]      special_val_s;

  // Stage 1: order by magnitude, build significands, align and spot specials.
  always_comb begin
    if (bus.b[30:0] > bus.a[30:0]) begin
      l_s = bus.b;
      s_s = bus.a;
    end else begin
      l_s = bus.a;
      s_s = bus.b;
    end
    sig_l_s = (l_s.exp != 8'd0) ? {1'b1, l_s.man} : 24'd0;
    sig_s_s = (s_s.exp != 8'd0) ? {1'b1, s_s.man} : 24'd0;
    d_s     = l_s.exp - s_s.exp;
    if (d_s >= 8'd25) begin
      align_s = 24'd0;
    end else begin
      align_s = sig_s_s >> d_s;
    end
    nan_a_s = (&bus.a[30:23]) && (bus.a[22:0] != 23'd0);
    nan_b_s = (&bus.b[30:23]) && (bus.b[22:0] != 23'd0);
    inf_a_s = (&bus.a[30:23]) && (bus.a[22:0] == 23'd0);
    inf_b_s = (&bus.b[30:23]) && (bus.b[22:0] == 23'd0);
    // The larger-magnitude operand carries the infinity whenever one exists.
    if (nan_a_s || nan_b_s || (inf_a_s && inf_b_s && (bus.a[31] != bus.b[31]))) begin
      special_s     = 1'b1;
      special_val_s = QNAN;
    end else if (inf_a_s || inf_b_s) begin
      special_s     = 1'b1;
      special_val_s = l_s;
    end else begin
      special_s     = 1'b0;
      special_val_s = 32'd0;
    end
    neg_zero_s = (bus.a[30:23] == 8'd0) && (bus.b[30:23] == 8'd0) && bus.a[31] && bus.b[31];
  end

  logic             valid1_r;
  logic             sign_l_r, sub_r, special_r, neg_zero_r;
  logic [EXP_W-1:0] exp_l_r;
  logic [SIG_W-1:0] sig_l_r, align_r;
  logic [31:0]      special_val_r;

  // Stage-1 valid bit, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid1_r <= 1'b0;
    end else begin
      valid1_r <= bus.in_valid;
    end
  end

  // Stage-1 data registers carry no reset; valid gates their use.
  always_ff @(posedge clk) begin
    sign_l_r      <= l_s.sign;
    sub_r         <= l_s.sign ^ s_s.sign;
    exp_l_r       <= l_s.exp;
    sig_l_r       <= sig_l_s;
    align_r       <= align_s;
    special_r     <= special_s;
    special_val_r <= special_val_s;
    neg_zero_r    <= neg_zero_s;
  end

  logic [ADD_W-1:0] add_b_s, raw_s;
  logic             cout_s;

  // Subtraction is L + ~S + 1; L >= S so the result is never negative.
  assign add_b_s = sub_r ? ~{1'b0, align_r} : {1'b0, align_r};

  rda_fp_adder_rda u_rda (
    .a    ({1'b0, sig_l_r}),
    .b    (add_b_s),
    .cin  (sub_r),
    .s    (raw_s),
    .cout (cout_s)
  );

  logic [4:0]       k_s;
  logic [SIG_W-1:0] shifted_s;
  logic [MAN_W-1:0] man_n_s;
  logic [9:0]       exp_n_s;
  logic [31:0]      result_s;

  // Stage 2: normalize the raw sum and pack, with overflow/underflow handling.
  always_comb begin
    k_s       = lzc_sig(raw_s[23:0]);
    shifted_s = raw_s[23:0] << k_s;
    if (raw_s[24]) begin
      man_n_s = raw_s[23:1];
      exp_n_s = {2'b00, exp_l_r} + 10'd1;
    end else if (raw_s[23]) begin
      man_n_s = raw_s[22:0];
      exp_n_s = {2'b00, exp_l_r};
    end else begin
      man_n_s = shifted_s[22:0];
      exp_n_s = {2'b00, exp_l_r} - {5'd0, k_s};
    end
    if (special_r) begin
      result_s = special_val_r;
    end else if (raw_s == 25'd0) begin
      result_s = neg_zero_r ? 32'h8000_0000 : 32'h0000_0000;
    end else if (!exp_n_s[9] && (exp_n_s >= 10'(EXP_MAX))) begin
      result_s = {sign_l_r, POS_INF[30:0]};
    end else if (exp_n_s[9] || (exp_n_s == 10'd0)) begin
      result_s = {sign_l_r, 31'd0};
    end else begin
      result_s = {sign_l_r, exp_n_s[7:0], man_n_s};
    end
  end

  logic        out_valid_r;
  logic [31:0] sum_r;

  // Output registers; sum only advances when stage 1 holds a live operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      sum_r       <= 32'd0;
    end else begin
      out_valid_r <= valid1_r;
      sum_r       <= valid1_r ? result_s : sum_r;
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;

endmodule

// File: tb/tb_rda_fp_adder.sv
// Directed scoreboard bench for rda_fp_adder: expected sums are queued at
// issue and checked, with their 2-cycle latency, as results emerge.
module tb_rda_fp_adder;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;

  logic [31:0] exp_q[$];
  int          iss_q[$];

  rda_fp_adder_if bus ();

  rda_fp_adder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, want);
    end
  endtask

  // One clock: drive inputs, model reset flush / issue, then check outputs.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] want, input logic r);
    logic [31:0] e;
    int          t;
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    rst          = r;
    if (r) begin
      exp_q.delete();
      iss_q.delete();
    end else if (v) begin
      exp_q.push_back(want);
      iss_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check32("spurious_out_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        t = iss_q.pop_front();
        check32("sum", bus.sum, e);
        check32("latency", 32'(cyc - t), 32'd1);
      end
    end
    if (r) begin
      check32("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check32("rst_sum", bus.sum, 32'd0);
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    bus.in_valid = 1'b0;
    bus.a = 32'd0;
    bus.b = 32'd0;
    rst = 1'b1;
    @(negedge clk);
    step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);

    // Arithmetic cases
    step(1'b1, 32'h40C0_0000, 32'h4100_0000, 32'h4160_0000, 1'b0);
    step(1'b1, 32'h411C_0000, 32'h3F10_0000, 32'h4125_0000, 1'b0);
    step(1'b1, 32'h3F10_0000, 32'h411C_0000, 32'h4125_0000, 1'b0);
    step(1'b1, 32'hC0C0_0000, 32'hC100_0000, 32'hC160_0000, 1'b0);
    step(1'b1, 32'hC0C0_0000, 32'h4100_0000, 32'h4000_0000, 1'b0);
    // Specials
    step(1'b1, 32'h7F80_0000, 32'hC0C0_0000, 32'h7F80_0000, 1'b0);
    step(1'b1, 32'h0000_0000, 32'h7F80_0000, 32'h7F80_0000, 1'b0);
    step(1'b1, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1'b0);
    step(1'b1, 32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, 1'b0);
    step(1'b1, 32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b0);
    // Cancellation, zeros, overflow
    step(1'b1, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 1'b0);
    step(1'b1, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 1'b0);
    step(1'b1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0);
    step(1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
    // Denormal flush, alignment boundaries d=23 and d=24, underflow
    step(1'b1, 32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
    step(1'b1, 32'h4B00_0000, 32'h3F80_0000, 32'h4B00_0001, 1'b0);
    step(1'b1, 32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000, 1'b0);
    step(1'b1, 32'h0080_0000, 32'h8080_0001, 32'h8000_0000, 1'b0);
    step(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);

    // Back-to-back issue with reset in the second cycle: first two discarded
    step(1'b1, 32'h40C0_0000, 32'h4100_0000, 32'h4160_0000, 1'b0);
    step(1'b1, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b1);
    step(1'b1, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 1'b0);
    step(1'b1, 32'h4040_0000, 32'h3F80_0000, 32'h4080_0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    end

    check32("drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
